// File: rtl/adc_pkg.sv
// adc_pkg
//   Shared definitions for the PCF8591 scan scheduler slice.
//   - FSM state encoding (plain logic constants so older tools can read them)
//   - PCF8591 control-byte field positions
//   - CHAN_NONE marker used to force a dummy read after a channel switch
//   - ctrl_byte(): builds the control byte for a single-channel read
package adc_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_TICK = 3'd1;
    localparam state_t ST_ISSUE     = 3'd2;
    localparam state_t ST_WAIT_DONE = 3'd3;
    localparam state_t ST_EVAL      = 3'd4;

    // PCF8591 control byte fields
    localparam int CTRL_AUTOINC_BIT = 2;
    localparam int CTRL_AOUT_EN_BIT = 6;

    // Out-of-range channel code: never equal to a real channel
    localparam logic [2:0] CHAN_NONE = 3'b100;

    // Single-channel read, no auto-increment, analog output disabled
    function automatic logic [7:0] ctrl_byte(input logic [1:0] chan);
        logic [7:0] b;
        b                   = 8'h00;
        b[1:0]              = chan;
        b[CTRL_AUTOINC_BIT] = 1'b0;
        b[CTRL_AOUT_EN_BIT] = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/adc_next_chan.sv
// adc_next_chan
//   Combinational cyclic priority picker. Returns the first set mask bit
//   strictly after cur_chan, wrapping 3->0. cur_chan itself is the last
//   candidate, so a single-bit mask always reselects the same channel.
// Ports:
//   mask      in  4  channel enable mask
//   cur_chan  in  2  channel used in the previous slot
//   next_chan out 2  selected channel (cur_chan when nothing found)
//   found     out 1  at least one mask bit set
module adc_next_chan (
    input  logic [3:0] mask,
    input  logic [1:0] cur_chan,
    output logic [1:0] next_chan,
    output logic       found
);

    logic [1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        next_chan = cur_chan;
        found     = 1'b0;
        idx       = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = cur_chan + 2'(k);
            if (mask[idx]) begin
                next_chan = idx;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_sched.sv
// adc_scan_sched
//   Sequences the PCF8591 I2C transaction engine round-robin across the
//   enabled ADC inputs, one conversion slot per interval tick. A PCF8591
//   read returns the previous conversion, so after every channel change the
//   first byte is thrown away and the read repeated. Failed transactions are
//   retried up to MAX_RETRY times before the channel is skipped for the slot.
// Ports:
//   clk_in, rst_in           clock, async active-high reset
//   enable_in, chan_mask_in  scan enable and channel mask (bit n = AIN n)
//   xfer_req_out/ctrl_out    request level and control byte to the engine
//   xfer_done_in/data_in     completion pulse with read byte
//   xfer_err_in              NACK/abort pulse
//   sample_valid/chan/data   fresh sample publication
//   ch_data_out              last fresh sample per channel, ch n at [8n+7:8n]
//   err_flags_out            sticky per-channel skip flags
//   busy_out                 scheduler not idle
module adc_scan_sched
    import adc_pkg::*;
#(
    parameter logic [15:0] INTERVAL  = 16'd50000,
    parameter logic [19:0] TIMEOUT   = 20'd500000,
    parameter int          MAX_RETRY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic [3:0]  chan_mask_in,
    output logic        xfer_req_out,
    output logic [7:0]  xfer_ctrl_out,
    input  logic        xfer_done_in,
    input  logic [7:0]  xfer_data_in,
    input  logic        xfer_err_in,
    output logic        sample_valid_out,
    output logic [1:0]  sample_chan_out,
    output logic [7:0]  sample_data_out,
    output logic [31:0] ch_data_out,
    output logic [3:0]  err_flags_out,
    output logic        busy_out
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t          state;
    logic [15:0]     ival_cnt;
    logic [19:0]     tmo_cnt;
    logic [RW-1:0]   retry;
    logic [1:0]      cur_chan;
    logic [2:0]      last_chan;
    logic            xfer_ok;
    logic [7:0]      xfer_byte;
    logic            tick;
    logic [1:0]      next_chan;
    logic            found;

    adc_next_chan u_next_chan (
        .mask      (chan_mask_in),
        .cur_chan  (cur_chan),
        .next_chan (next_chan),
        .found     (found)
    );

    assign tick     = (ival_cnt == INTERVAL - 16'd1);
    assign busy_out = (state != ST_IDLE);

    // Free-running slot pacing counter; a tick that lands while a slot is
    // still in progress is simply missed and the next one is used.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ival_cnt <= '0;
        end else if (tick) begin
            ival_cnt <= '0;
        end else begin
            ival_cnt <= ival_cnt + 16'd1;
        end
    end

    // Scheduler FSM. cur_chan resets to 3 so the first selection starts
    // the search at AIN0.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= ST_IDLE;
            tmo_cnt          <= '0;
            retry            <= '0;
            cur_chan         <= 2'd3;
            last_chan        <= CHAN_NONE;
            xfer_ok          <= 1'b0;
            xfer_byte        <= 8'h00;
            xfer_req_out     <= 1'b0;
            xfer_ctrl_out    <= 8'h00;
            sample_valid_out <= 1'b0;
            sample_chan_out  <= 2'd0;
            sample_data_out  <= 8'h00;
            ch_data_out      <= '0;
            err_flags_out    <= '0;
        end else begin
            sample_valid_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable_in && (chan_mask_in != 4'd0)) begin
                        state <= ST_WAIT_TICK;
                    end
                end
                ST_WAIT_TICK: begin
                    if (tick) begin
                        if (enable_in && found) begin
                            cur_chan <= next_chan;
                            state    <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_ISSUE: begin
                    xfer_ctrl_out <= ctrl_byte(cur_chan);
                    xfer_req_out  <= 1'b1;
                    tmo_cnt       <= '0;
                    state         <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // err takes precedence when both pulses coincide
                    if (xfer_err_in || xfer_done_in || (tmo_cnt == TIMEOUT - 20'd1)) begin
                        xfer_req_out <= 1'b0;
                        xfer_ok      <= xfer_done_in && !xfer_err_in;
                        xfer_byte    <= xfer_data_in;
                        state        <= ST_EVAL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 20'd1;
                    end
                end
                ST_EVAL: begin
                    if (xfer_ok) begin
                        if ({1'b0, cur_chan} != last_chan) begin
                            // stale byte from the previous channel: reread
                            last_chan <= {1'b0, cur_chan};
                            state     <= ST_ISSUE;
                        end else begin
                            sample_valid_out              <= 1'b1;
                            sample_chan_out               <= cur_chan;
                            sample_data_out               <= xfer_byte;
                            ch_data_out[8*cur_chan +: 8]  <= xfer_byte;
                            err_flags_out[cur_chan]       <= 1'b0;
                            retry                         <= '0;
                            state                         <= ST_WAIT_TICK;
                        end
                    end else begin
                        // engine state unknown after a failure: force a dummy read
                        last_chan <= CHAN_NONE;
                        if (retry < RW'(MAX_RETRY)) begin
                            retry <= retry + 1'b1;
                            state <= ST_ISSUE;
                        end else begin
                            err_flags_out[cur_chan] <= 1'b1;
                            retry                   <= '0;
                            state                   <= ST_WAIT_TICK;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/adc_scan_sched.md
Name: adc_scan_sched

Overview:
- Scheduler that sequences the PCF8591 I2C transaction engine across the four ADC input channels.
- Round-robin over enabled channels. Each conversion slot is paced by a programmable interval timer.
- Handles the PCF8591 property that a read returns the result of the previous conversion: after every channel switch, the first (stale) byte is discarded.
- Publishes per-channel results with valid pulses. Sits between the I2C engine and the application logic (display/filter).

Parameters:
- INTERVAL, 16'd50000, clk_in cycles between conversion slot starts (min 1).
- TIMEOUT, 20'd500000, clk_in cycles allowed from xfer_req_out rise to done/err before abort.
- MAX_RETRY, 2, retries per channel slot after err/timeout before the slot is skipped.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- enable_in  in  1  scanning enabled
- chan_mask_in  in  4  channel enable mask, bit n = AIN n
- xfer_req_out  out  1  transaction request to I2C engine (level)
- xfer_ctrl_out  out  8  PCF8591 control byte, {6'b0, chan[1:0]}
- xfer_done_in  in  1  one-cycle pulse: transaction complete, data valid
- xfer_data_in  in  8  byte read by engine, valid with xfer_done_in
- xfer_err_in  in  1  one-cycle pulse: NACK/abort
- sample_valid_out  out  1  one-cycle pulse, new fresh sample
- sample_chan_out  out  2  channel of the current sample
- sample_data_out  out  8  sample value
- ch_data_out  out  32  last fresh sample per channel, ch n at [8n+7:8n]
- err_flags_out  out  4  sticky: channel n skipped after retries exhausted; cleared on that channel's next fresh sample
- busy_out  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0. Internal last_chan = 3'b100 (invalid, forces a dummy read). Interval counter = 0. Retry count = 0.
- Reset mid-transaction: xfer_req_out drops asynchronously. The engine must tolerate request withdrawal.
- FSM states: IDLE, WAIT_TICK, ISSUE, WAIT_DONE, EVAL.
- IDLE: move to WAIT_TICK when enable_in=1 and chan_mask_in != 0. Otherwise stay, busy_out=0.
- WAIT_TICK:
  - Free-running interval counter counts 0..INTERVAL-1 and wraps; its terminal count is the tick.
  - On the tick, sample chan_mask_in and select the next set bit after cur_chan, cyclic, wrapping 3->0.
  - If the mask is now 0, or enable_in=0, return to IDLE.
- ISSUE: drive xfer_ctrl_out = {6'b0, chan}, assert xfer_req_out, clear the timeout counter, go to WAIT_DONE.
- WAIT_DONE:
  - xfer_req_out and xfer_ctrl_out are held stable.
  - Exit on done, err, or timeout counter reaching TIMEOUT-1. xfer_req_out deasserts the cycle after the exit event.
  - If done and err arrive in the same cycle, err wins.
- EVAL, done case:
  - If chan != last_chan: set last_chan = chan, discard the data, go to ISSUE (dummy-read repeat; not counted as a retry).
  - Otherwise: sample_valid_out=1 for one cycle, with sample_chan_out/sample_data_out set. Update ch_data_out lane, clear err_flags_out[chan], reset retry count, go to WAIT_TICK.
- EVAL, err/timeout case:
  - last_chan = 3'b100.
  - If retry < MAX_RETRY: retry++ and go to ISSUE.
  - Otherwise: set err_flags_out[chan], reset retry count, go to WAIT_TICK (channel skipped this slot).
- enable_in deassert mid-transaction: the current transaction completes or times out and its result is published normally. The FSM then returns to IDLE at the next WAIT_TICK evaluation.
- Mask changes take effect only at slot selection. The current channel is never aborted.
- Single-channel mask: the same channel is reselected each tick. No dummy read occurs after the first one, since last_chan matches.
- Latency, tick to sample_valid_out: engine time + 2 cycles (ISSUE, EVAL). Add one more engine transaction when a dummy read occurs.
- Widths: retry counter $clog2(MAX_RETRY+1). Timeout counter 20 bits. Interval counter 16 bits.

Decomposition:
- Package adc_pkg holds:
  - FSM state enum
  - PCF8591 control-byte field constants: AUTOINC bit2, AOUT_EN bit6
  - CHAN_NONE = 3'b100
- Sub-module adc_next_chan: combinational cyclic priority picker (mask, current channel -> next channel, found flag). Reused by other scanners.
- Interval and timeout counters stay inline.

Test Plan:
- Reset then enable=1, mask=4'b0001, INTERVAL=100, engine returns 0x11 then 0x22 → the first done is discarded. sample_valid_out then fires with chan 0, data 0x22, and ch_data_out[7:0]=0x22.
- Mask=4'b1011, engine returns the channel index ×0x10 → publish order is 0,1,3,0,…, each preceded by one dummy transaction. ch_data_out=0x30_00_10_00 after one round.
- Mask=4'b0100, engine pulses err on 3 consecutive transactions (MAX_RETRY=2) → exactly 3 requests issued, err_flags_out=4'b0100, no sample_valid_out. The next successful slot clears the flag.
- Engine never responds, TIMEOUT=1000 → xfer_req_out drops at cycle 1000 after its rise, then a retry is issued.
- done and err asserted in the same cycle → treated as err: no sample is published and a retry is issued.
- rst_in asserted while xfer_req_out=1 → all outputs are 0 immediately. After release, the first transaction on any channel is a dummy read.
